// File: rtl/npcg_pm_pkg.sv
// Shared PM-layer encodings for the NPCG MNC blocks: PM command one-hots,
// option codes, NAND opcode bytes and the short-data command FSM states.
package npcg_pm_pkg;

    localparam logic [7:0] PM_CMD_TIMER = 8'h01;
    localparam logic [7:0] PM_CMD_DI    = 8'h02;
    localparam logic [7:0] PM_CMD_CAL   = 8'h08;
    localparam logic [7:0] PM_CMD_WBSY  = 8'h20;
    localparam logic [7:0] PM_CMD_PBR   = 8'h40;

    localparam logic [2:0] OPT_NONE     = 3'b000;
    localparam logic [2:0] OPT_TIM_PRE  = 3'b001;
    localparam logic [2:0] OPT_DI       = 3'b001;
    localparam logic [2:0] OPT_TIM_POST = 3'b100;

    localparam logic [7:0] NAND_READ_ID      = 8'h90;
    localparam logic [7:0] NAND_PARAM_PAGE   = 8'hEC;
    localparam logic [7:0] NAND_GET_FEATURES = 8'hEE;

    typedef enum logic [1:0] {
        MODE_READ_ID      = 2'b00,
        MODE_PARAM_PAGE   = 2'b01,
        MODE_GET_FEATURES = 2'b10,
        MODE_RAW          = 2'b11
    } mode_t;

    typedef enum logic [3:0] {
        S_IDLE, S_PBR, S_CAL, S_CMDB, S_ADDR, S_WBSY, S_TIM1, S_DI, S_TIM2, S_DONE
    } state_t;

    function automatic logic [2:0] clamp_addr_cnt(input logic [2:0] req, input int unsigned max_cnt);
        return ({29'b0, req} > max_cnt) ? 3'(max_cnt) : req;
    endfunction

endpackage

// File: rtl/npcg_ca_sequencer.sv
// Command/address byte sequencer: after load, emits the command byte for one
// cycle, then addr_cnt address bytes LSB first; done marks the final byte.
module npcg_ca_sequencer #(
    parameter int MaxAddrCycles = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [7:0]  cmd_byte,
    input  logic [39:0] addr_bytes,
    input  logic [2:0]  addr_cnt,
    output logic        ca_select,
    output logic [7:0]  ca_data,
    output logic        done
);

    logic       busy;
    logic [2:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            idx  <= 3'd0;
        end else if (load) begin
            busy <= 1'b1;
            idx  <= 3'd0;
        end else if (busy) begin
            if (idx == addr_cnt) begin
                busy <= 1'b0;
            end
            idx <= idx + 3'd1;
        end
    end

    // idx 0 is the command byte, idx k>0 is address byte k-1
    always_comb begin
        ca_select = 1'b0;
        ca_data   = 8'h00;
        if (busy) begin
            ca_select = (idx != 3'd0);
            if (idx == 3'd0) begin
                ca_data = cmd_byte;
            end
            for (int i = 0; i < MaxAddrCycles; i++) begin
                if ({29'b0, idx} == i + 1) begin
                    ca_data = addr_bytes[8*i +: 8];
                end
            end
        end
    end

    assign done = busy && (idx == addr_cnt);

endmodule

// File: rtl/npcg_toggle_mnc_readid_multi.sv
// Short-data NAND command generator (READ ID / PARAM PAGE / GET FEATURES / RAW):
// drives the PM layer through CMD, address, timed waits and a counted DI burst.
//
// state  | meaning
// IDLE   | ready for a command
// PBR    | wait for all PM engines ready
// CAL    | announce command/address latch, addr count on NumOfData
// CMDB   | command byte on CA bus
// ADDR   | address bytes on CA bus
// WBSY   | ready/busy poll (PARAM PAGE only)
// TIM1   | tWHR wait before data-in
// DI     | data-in burst of iLength beats
// TIM2   | trailing wait
// DONE   | wait for final PM step, pulse oLastStep
module npcg_toggle_mnc_readid_multi
    import npcg_pm_pkg::*;
#(
    parameter int         NumberOfWays  = 4,
    parameter int         MaxAddrCycles = 5,
    parameter int         TWhrCycles    = 14,
    parameter int         TPostCycles   = 7,
    parameter logic [4:0] TargetID      = 5'b00101
) (
    input  logic                    iSystemClock,
    input  logic                    iReset_n,
    input  logic [5:0]              iOpcode,
    input  logic [4:0]              iTargetID,
    input  logic [4:0]              iSourceID,
    input  logic [15:0]             iLength,
    input  logic                    iCMDValid,
    output logic                    oCMDReady,
    input  logic [NumberOfWays-1:0] iWaySelect,
    input  logic [15:0]             iColAddress,
    input  logic [23:0]             iRowAddress,
    output logic                    oStart,
    output logic                    oLastStep,
    output logic                    oError,
    output logic [31:0]             oReadData,
    output logic                    oReadValid,
    output logic                    oReadLast,
    input  logic                    iReadReady,
    input  logic [7:0]              iPM_Ready,
    input  logic [7:0]              iPM_LastStep,
    output logic [7:0]              oPM_PCommand,
    output logic [2:0]              oPM_PCommandOption,
    output logic [NumberOfWays-1:0] oPM_TargetWay,
    output logic [15:0]             oPM_NumOfData,
    output logic                    oPM_CASelect,
    output logic [7:0]              oPM_CAData,
    input  logic [31:0]             iPM_ReadData,
    input  logic                    iPM_ReadValid,
    input  logic                    iPM_ReadLast,
    output logic                    oPM_ReadReady
);

    state_t                  state_q, state_d;
    mode_t                   mode_q, acc_mode;
    logic [15:0]             len_q;
    logic [NumberOfWays-1:0] way_q;
    logic [7:0]              cmd_q, acc_cmd;
    logic [39:0]             addr_q, acc_addr;
    logic [2:0]              cnt_q, acc_cnt;
    logic [15:0]             beat_cnt;
    logic                    err_q;
    logic                    trigger, accept, seq_load, seq_done;
    logic                    in_di, beat, is_last, overrun;
    logic                    unused_bits;

    assign unused_bits = ^{iSourceID, iPM_Ready[7], iPM_LastStep[7:4]};

    assign trigger   = iCMDValid && (iTargetID == TargetID) && (iOpcode[5:2] == 4'b1010);
    assign accept    = trigger && (state_q == S_IDLE);
    assign oCMDReady = (state_q == S_IDLE);
    assign oStart    = accept;
    assign acc_mode  = mode_t'(iOpcode[1:0]);

    always_comb begin
        acc_cmd  = NAND_READ_ID;
        acc_addr = {iRowAddress, iColAddress};
        acc_cnt  = 3'd1;
        case (acc_mode)
            MODE_PARAM_PAGE:   acc_cmd = NAND_PARAM_PAGE;
            MODE_GET_FEATURES: acc_cmd = NAND_GET_FEATURES;
            MODE_RAW: begin
                acc_cmd  = iColAddress[7:0];
                acc_addr = {19'b0, iRowAddress[20:0]};
                acc_cnt  = clamp_addr_cnt(iRowAddress[23:21], MaxAddrCycles);
            end
            default: ;
        endcase
    end

    always_ff @(posedge iSystemClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_READ_ID;
            len_q   <= 16'd0;
            way_q   <= '0;
            cmd_q   <= 8'h00;
            addr_q  <= 40'd0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mode_q <= acc_mode;
                len_q  <= iLength;
                way_q  <= iWaySelect;
                cmd_q  <= acc_cmd;
                addr_q <= acc_addr;
                cnt_q  <= acc_cnt;
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        oPM_PCommand       = 8'h00;
        oPM_PCommandOption = OPT_NONE;
        oPM_NumOfData      = 16'd0;
        seq_load           = 1'b0;
        oLastStep          = 1'b0;
        case (state_q)
            S_IDLE: if (accept) state_d = S_PBR;
            S_PBR: begin
                oPM_PCommand = PM_CMD_PBR;
                if (iPM_Ready[6:0] == 7'h7F) state_d = S_CAL;
            end
            S_CAL: begin
                oPM_PCommand  = PM_CMD_CAL;
                oPM_NumOfData = {13'd0, cnt_q};
                if (iPM_Ready[3]) begin
                    seq_load = 1'b1;
                    state_d  = S_CMDB;
                end
            end
            S_CMDB, S_ADDR: begin
                oPM_PCommand  = PM_CMD_CAL;
                oPM_NumOfData = {13'd0, cnt_q};
                if (seq_done) begin
                    state_d = (mode_q == MODE_PARAM_PAGE) ? S_WBSY : S_TIM1;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_WBSY: begin
                oPM_PCommand = PM_CMD_WBSY;
                if (iPM_LastStep[2]) state_d = S_TIM1;
            end
            S_TIM1: begin
                oPM_PCommand       = PM_CMD_TIMER;
                oPM_PCommandOption = OPT_TIM_PRE;
                oPM_NumOfData      = 16'(TWhrCycles);
                if (iPM_LastStep[3]) state_d = (len_q == 16'd0) ? S_TIM2 : S_DI;
            end
            S_DI: begin
                oPM_PCommand       = PM_CMD_DI;
                oPM_PCommandOption = OPT_DI;
                oPM_NumOfData      = len_q;
                if (iPM_LastStep[0]) state_d = S_TIM2;
            end
            S_TIM2: begin
                oPM_PCommand       = PM_CMD_TIMER;
                oPM_PCommandOption = OPT_TIM_POST;
                oPM_NumOfData      = 16'(TPostCycles);
                if (iPM_LastStep[1]) state_d = S_DONE;
            end
            S_DONE: begin
                if (iPM_LastStep[0]) begin
                    oLastStep = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign oPM_TargetWay = (state_q != S_IDLE) ? way_q : '0;

    npcg_ca_sequencer #(.MaxAddrCycles(MaxAddrCycles)) u_ca_seq (
        .clk        (iSystemClock),
        .rst_n      (iReset_n),
        .load       (seq_load),
        .cmd_byte   (cmd_q),
        .addr_bytes (addr_q),
        .addr_cnt   (cnt_q),
        .ca_select  (oPM_CASelect),
        .ca_data    (oPM_CAData),
        .done       (seq_done)
    );

    // Data path passes through only during DI; last flag comes from our own count
    assign in_di         = (state_q == S_DI);
    assign oReadValid    = in_di && iPM_ReadValid;
    assign oReadData     = in_di ? iPM_ReadData : 32'd0;
    assign oPM_ReadReady = in_di && iReadReady;
    assign beat          = oReadValid && iReadReady;
    assign is_last       = (len_q != 16'd0) && (beat_cnt == len_q - 16'd1);
    assign overrun       = (beat_cnt >= len_q);
    assign oReadLast     = oReadValid && is_last;
    assign oError        = err_q;

    always_ff @(posedge iSystemClock or negedge iReset_n) begin
        if (!iReset_n) begin
            beat_cnt <= 16'd0;
            err_q    <= 1'b0;
        end else if (accept) begin
            beat_cnt <= 16'd0;
            err_q    <= 1'b0;
        end else if (beat) begin
            if (beat_cnt != 16'hFFFF) beat_cnt <= beat_cnt + 16'd1;
            if ((iPM_ReadLast != is_last) || overrun) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_npcg_toggle_mnc_readid_multi.sv
// Directed bench for npcg_toggle_mnc_readid_multi: a simple PM responder per
// command, logs of PM commands and CA bytes, compared against hand-built lists.
module tb_npcg_toggle_mnc_readid_multi;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [5:0]  iOpcode;
    logic [4:0]  iTargetID, iSourceID;
    logic [15:0] iLength, iColAddress;
    logic        iCMDValid, oCMDReady;
    logic [3:0]  iWaySelect, oPM_TargetWay;
    logic [23:0] iRowAddress;
    logic        oStart, oLastStep, oError;
    logic [31:0] oReadData, iPM_ReadData;
    logic        oReadValid, oReadLast, iReadReady;
    logic [7:0]  iPM_Ready, iPM_LastStep, oPM_PCommand, oPM_CAData;
    logic [2:0]  oPM_PCommandOption;
    logic [15:0] oPM_NumOfData;
    logic        oPM_CASelect, iPM_ReadValid, iPM_ReadLast, oPM_ReadReady;

    npcg_toggle_mnc_readid_multi dut (
        .iSystemClock(clk), .iReset_n(rst_n), .iOpcode(iOpcode), .iTargetID(iTargetID),
        .iSourceID(iSourceID), .iLength(iLength), .iCMDValid(iCMDValid), .oCMDReady(oCMDReady),
        .iWaySelect(iWaySelect), .iColAddress(iColAddress), .iRowAddress(iRowAddress),
        .oStart(oStart), .oLastStep(oLastStep), .oError(oError), .oReadData(oReadData),
        .oReadValid(oReadValid), .oReadLast(oReadLast), .iReadReady(iReadReady),
        .iPM_Ready(iPM_Ready), .iPM_LastStep(iPM_LastStep), .oPM_PCommand(oPM_PCommand),
        .oPM_PCommandOption(oPM_PCommandOption), .oPM_TargetWay(oPM_TargetWay),
        .oPM_NumOfData(oPM_NumOfData), .oPM_CASelect(oPM_CASelect), .oPM_CAData(oPM_CAData),
        .iPM_ReadData(iPM_ReadData), .iPM_ReadValid(iPM_ReadValid), .iPM_ReadLast(iPM_ReadLast),
        .oPM_ReadReady(oPM_ReadReady)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ent(input logic [15:0] n, input logic [2:0] o, input logic [7:0] c);
        return {n, 5'b0, o, c};
    endfunction

    logic [31:0] cmd_log[$], exp_cmd[$];
    logic [8:0]  ca_log[$], exp_ca[$];
    int beats, last_cnt, last_idx, step_cnt, start_cnt, valid_cnt, wbsy_cycles, sel_cycles, err_first;
    logic err_at_accept;

    task automatic compare_logs(input string tag);
        check_val({tag, "_ncmd"}, cmd_log.size(), exp_cmd.size());
        for (int i = 0; i < exp_cmd.size() && i < cmd_log.size(); i++)
            check_val($sformatf("%s_cmd%0d", tag, i), cmd_log[i], exp_cmd[i]);
        check_val({tag, "_nca"}, ca_log.size(), exp_ca.size());
        for (int i = 0; i < exp_ca.size() && i < ca_log.size(); i++)
            check_val($sformatf("%s_ca%0d", tag, i), {23'd0, ca_log[i]}, {23'd0, exp_ca[i]});
    endtask

    task automatic run_cmd(input logic [1:0] mode, input logic [15:0] len, input logic [15:0] col,
                           input logic [23:0] row, input int n_send, input int pm_last_idx,
                           input int wbsy_hold, input bit bp, input bit abort_di);
        logic [31:0] prev, cur;
        int hold;
        bit seen_tim2, finished, done;
        cmd_log.delete(); ca_log.delete();
        beats = 0; last_cnt = 0; last_idx = -1; step_cnt = 0; start_cnt = 0;
        valid_cnt = 0; wbsy_cycles = 0; sel_cycles = 0; err_first = -1;
        prev = '0; hold = 0; seen_tim2 = 0; finished = 0; done = 0;
        @(negedge clk);
        iOpcode = {4'b1010, mode}; iTargetID = 5'b00101; iLength = len;
        iColAddress = col; iRowAddress = row; iWaySelect = 4'b0100; iCMDValid = 1'b1;
        #1;
        check_val("accept_ready", 32'(oCMDReady), 1);
        check_val("accept_start", 32'(oStart), 1);
        @(negedge clk);
        err_at_accept = oError;
        check_val("way_latched", 32'(oPM_TargetWay), 32'h4);
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            cur = {oPM_NumOfData, 5'b0, oPM_PCommandOption, oPM_PCommand};
            if (cur != prev) hold = 0; else hold++;
            if (cur != prev && oPM_PCommand != 8'h00) cmd_log.push_back(cur);
            prev = cur;
            if (oPM_PCommand == 8'h08 && (oPM_CASelect || oPM_CAData != 8'h00))
                ca_log.push_back({oPM_CASelect, oPM_CAData});
            if (oPM_CASelect) sel_cycles++;
            if (oError && err_first < 0) err_first = beats;
            iPM_LastStep = 8'h00; iPM_ReadValid = 1'b0; iPM_ReadLast = 1'b0; iReadReady = 1'b1;
            iCMDValid = (oPM_PCommand != 8'h00);
            if (finished) begin
                check_val("ready_after_done", 32'(oCMDReady), 1);
                done = 1;
            end else if (oPM_PCommand == 8'h20) begin
                wbsy_cycles++;
                if (hold == wbsy_hold) iPM_LastStep[2] = 1'b1;
            end else if (oPM_PCommand == 8'h01 && oPM_PCommandOption == 3'b001) begin
                if (hold == 2) iPM_LastStep[3] = 1'b1;
            end else if (oPM_PCommand == 8'h02) begin
                if (abort_di && beats == 1) begin
                    iCMDValid = 1'b0;
                    rst_n = 1'b0;
                    #1;
                    check_val("rst_pcmd", 32'(oPM_PCommand), 0);
                    check_val("rst_ready", 32'(oCMDReady), 1);
                    check_val("rst_way", 32'(oPM_TargetWay), 0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    @(negedge clk);
                    check_val("ready_after_rst", 32'(oCMDReady), 1);
                    done = 1;
                end else if (beats < n_send) begin
                    iPM_ReadValid = 1'b1;
                    iPM_ReadData  = 32'hD000_0000 + beats;
                    iPM_ReadLast  = (beats == pm_last_idx);
                    iReadReady    = !(bp && (cyc % 3 == 1));
                end else begin
                    iPM_LastStep[0] = 1'b1;
                end
            end else if (oPM_PCommand == 8'h01 && oPM_PCommandOption == 3'b100) begin
                seen_tim2 = 1;
                if (hold == 2) iPM_LastStep[1] = 1'b1;
            end else if (oPM_PCommand == 8'h00 && seen_tim2) begin
                iPM_LastStep[0] = 1'b1;
                finished = 1;
            end
            if (!done) begin
                #1;
                if (oReadValid) valid_cnt++;
                if (oStart) start_cnt++;
                if (oLastStep) step_cnt++;
                if (bp && oReadValid && !iReadReady)
                    check_val("bp_pm_ready", 32'(oPM_ReadReady), 0);
                if (oReadValid && iReadReady) begin
                    if (oReadLast) begin
                        last_cnt++;
                        last_idx = beats;
                    end
                    if (beats == 0) check_val("data_pass", oReadData, 32'hD000_0000);
                    beats++;
                end
            end
        end
        if (!done) check_val("timeout", 0, 1);
        iCMDValid = 1'b0; iPM_ReadValid = 1'b0; iPM_LastStep = 8'h00; iReadReady = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; iOpcode = '0; iTargetID = '0; iSourceID = 5'd3; iLength = '0;
        iCMDValid = 1'b0; iWaySelect = '0; iColAddress = '0; iRowAddress = '0;
        iReadReady = 1'b1; iPM_Ready = 8'hFF; iPM_LastStep = '0; iPM_ReadData = '0;
        iPM_ReadValid = 1'b0; iPM_ReadLast = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_ready0", 32'(oCMDReady), 1);
        check_val("rst_pcmd0", 32'(oPM_PCommand), 0);
        check_val("rst_flags0", 32'({oStart, oLastStep, oError, oReadValid, oReadLast, oPM_CASelect, oPM_ReadReady}), 0);
        check_val("rst_num0", 32'({oPM_NumOfData, oPM_CAData, oPM_TargetWay}), 0);
        rst_n = 1'b1;

        @(negedge clk);
        iOpcode = 6'b101000; iTargetID = 5'b00110; iCMDValid = 1'b1;
        #1 check_val("bad_target_start", 32'(oStart), 0);
        @(negedge clk);
        check_val("bad_target_ready", 32'(oCMDReady), 1);
        iCMDValid = 1'b0;

        // READ ID, len 2, col 0
        run_cmd(2'b00, 16'd2, 16'h0000, 24'h0, 2, 1, 0, 0, 0);
        exp_cmd = '{ent(0,0,8'h40), ent(1,0,8'h08), ent(14,1,8'h01), ent(2,1,8'h02), ent(7,4,8'h01)};
        exp_ca  = '{{1'b0,8'h90}, {1'b1,8'h00}};
        compare_logs("rid");
        check_val("rid_beats", beats, 2);
        check_val("rid_last_idx", last_idx, 1);
        check_val("rid_last_cnt", last_cnt, 1);
        check_val("rid_laststep", step_cnt, 1);
        check_val("rid_busy_start", start_cnt, 0);
        check_val("rid_err", 32'(oError), 0);

        // PARAM PAGE, len 64, WBSY done on its 40th cycle
        run_cmd(2'b01, 16'd64, 16'h1234, 24'h0, 64, 63, 39, 0, 0);
        exp_cmd = '{ent(0,0,8'h40), ent(1,0,8'h08), ent(0,0,8'h20), ent(14,1,8'h01), ent(64,1,8'h02), ent(7,4,8'h01)};
        exp_ca  = '{{1'b0,8'hEC}, {1'b1,8'h34}};
        compare_logs("pp");
        check_val("pp_wbsy_cycles", wbsy_cycles, 40);
        check_val("pp_beats", beats, 64);
        check_val("pp_last_idx", last_idx, 63);
        check_val("pp_err", 32'(oError), 0);
        check_val("pp_laststep", step_cnt, 1);

        // RAW, count field 7 clamps to 5
        run_cmd(2'b11, 16'd1, 16'h005A, 24'hFA2B3C, 1, 0, 0, 0, 0);
        exp_cmd = '{ent(0,0,8'h40), ent(5,0,8'h08), ent(14,1,8'h01), ent(1,1,8'h02), ent(7,4,8'h01)};
        exp_ca  = '{{1'b0,8'h5A}, {1'b1,8'h3C}, {1'b1,8'h2B}, {1'b1,8'h1A}, {1'b1,8'h00}, {1'b1,8'h00}};
        compare_logs("raw");
        check_val("raw_sel_cycles", sel_cycles, 5);
        check_val("raw_err", 32'(oError), 0);

        // GET FEATURES, len 0: no DI at all
        run_cmd(2'b10, 16'd0, 16'h0001, 24'h0, 0, -1, 0, 0, 0);
        exp_cmd = '{ent(0,0,8'h40), ent(1,0,8'h08), ent(14,1,8'h01), ent(7,4,8'h01)};
        exp_ca  = '{{1'b0,8'hEE}, {1'b1,8'h01}};
        compare_logs("gf0");
        check_val("gf0_valid", valid_cnt, 0);
        check_val("gf0_laststep", step_cnt, 1);

        // PM flags last on beat 3 of 4, with backpressure
        run_cmd(2'b00, 16'd4, 16'h0000, 24'h0, 4, 2, 0, 1, 0);
        check_val("err_first_beat", err_first, 3);
        check_val("err_beats", beats, 4);
        check_val("err_last_idx", last_idx, 3);
        check_val("err_last_cnt", last_cnt, 1);
        check_val("err_sticky", 32'(oError), 1);

        // reset during DI, then a normal command
        run_cmd(2'b00, 16'd4, 16'h0000, 24'h0, 4, 3, 0, 0, 1);
        check_val("err_cleared_on_accept", 32'(err_at_accept), 0);
        run_cmd(2'b00, 16'd2, 16'h00AB, 24'h0, 2, 1, 0, 0, 0);
        exp_cmd = '{ent(0,0,8'h40), ent(1,0,8'h08), ent(14,1,8'h01), ent(2,1,8'h02), ent(7,4,8'h01)};
        exp_ca  = '{{1'b0,8'h90}, {1'b1,8'hAB}};
        compare_logs("post_rst");
        check_val("post_rst_beats", beats, 2);
        check_val("post_rst_laststep", step_cnt, 1);
        check_val("post_rst_err", 32'(oError), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
